// File: rtl/midi_msg_parser.sv
// midi_msg_parser
//   Assembles channel-voice MIDI messages from a byte stream (with running
//   status), filters them by channel, and queues them in a FWFT FIFO.
// Ports:
//   clk, reset                 clock, async active-high reset
//   byte_in, byte_valid        received byte + one-cycle strobe
//   omni, chan_sel             channel filter (sampled at message completion)
//   msg_status/data1/data2     head message (zero while FIFO is empty)
//   msg_valid, msg_ready       head present / consumer accept
//   fifo_level                 messages held, 0..FIFO_DEPTH
//   overflow, drop_count       sticky drop flag, saturating drop counter
module midi_msg_parser #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [7:0]  NOTE_OFF_VEL = 8'h40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  input  logic                          omni,
  input  logic [3:0]                    chan_sel,
  output logic [7:0]                    msg_status,
  output logic [6:0]                    msg_data1,
  output logic [6:0]                    msg_data2,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {NO_STAT, WAIT_D1, WAIT_D2, SKIP} state_t;

  state_t     state;
  logic [7:0] run_stat;
  logic [6:0] data1;

  // Program change / channel pressure (0xC_, 0xD_) carry a single data byte.
  logic one_data;
  assign one_data = (run_stat[7:5] == 3'b110);

  logic       done, push, note_off;
  logic [6:0] cmp_d1, cmp_d2, push_d2;
  logic [7:0] push_stat;

  always_comb begin
    done      = byte_valid && !byte_in[7] &&
                ((state == WAIT_D1 && one_data) || state == WAIT_D2);
    cmp_d1    = (state == WAIT_D2) ? data1 : byte_in[6:0];
    cmp_d2    = (state == WAIT_D2) ? byte_in[6:0] : 7'd0;
    // Note On with velocity 0 is queued as a Note Off; running status keeps 9n.
    note_off  = (run_stat[7:4] == 4'h9) && (cmp_d2 == 7'd0);
    push_stat = note_off ? {4'h8, run_stat[3:0]} : run_stat;
    push_d2   = note_off ? NOTE_OFF_VEL[6:0] : cmp_d2;
    push      = done && (omni || run_stat[3:0] == chan_sel);
  end

  // Parser FSM. Real-time bytes (F8-FF) fall through untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NO_STAT;
      run_stat <= '0;
      data1    <= '0;
    end else if (byte_valid && byte_in < 8'hF8) begin
      if (byte_in >= 8'hF0) begin
        run_stat <= '0;
        state    <= SKIP;
      end else if (byte_in[7]) begin
        run_stat <= byte_in;
        state    <= WAIT_D1;
      end else begin
        case (state)
          WAIT_D1: begin
            data1 <= byte_in[6:0];
            if (!one_data) state <= WAIT_D2;
          end
          WAIT_D2: state <= WAIT_D1;
          default: ;
        endcase
      end
    end
  end

  // Message FIFO, first-word-fall-through.
  logic [21:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr_en, drop;

  assign msg_valid = (fifo_level != '0);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign pop       = msg_valid && msg_ready;
  // A pop frees the slot on the same edge, so a full FIFO can still accept.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {push_stat, cmp_d1, push_d2};
  end

  // Storage is not reset; gate outputs so an empty FIFO reads as zero.
  logic [21:0] head;
  assign head       = mem[rd_ptr];
  assign msg_status = msg_valid ? head[21:14] : 8'h00;
  assign msg_data1  = msg_valid ? head[13:7]  : 7'h00;
  assign msg_data2  = msg_valid ? head[6:0]   : 7'h00;

endmodule

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, message FIFO depth; power of two, >= 2.
REQ-002 Parameter NOTE_OFF_VEL, default 8'h40, velocity substituted when Note On with velocity 0 is converted.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 byte_in  input  8  received MIDI byte from the UART receiver.
REQ-006 byte_valid  input  1  one-cycle strobe; byte_in valid this cycle.
REQ-007 omni  input  1  1 = accept all channels; 0 = accept only chan_sel.
REQ-008 chan_sel  input  4  channel accepted when omni=0.
REQ-009 msg_status  output  8  status byte of head message.
REQ-010 msg_data1  output  7  first data byte of head message.
REQ-011 msg_data2  output  7  second data byte of head message; 0 for one-data-byte messages.
REQ-012 msg_valid  output  1  head message present (FIFO not empty).
REQ-013 msg_ready  input  1  consumer accepts head message.
REQ-014 fifo_level  output  $clog2(FIFO_DEPTH)+1  messages held.
REQ-015 overflow  output  1  sticky; message dropped on full FIFO.
REQ-016 drop_count  output  8  saturating count of dropped messages.

Function
REQ-017 States: NO_STAT (no running status), WAIT_D1, WAIT_D2, SKIP; bytes are processed only on byte_valid=1.
REQ-018 Bytes 8'hF8-8'hFF (real-time) are ignored in every state, with no change to state, running status or partial data.
REQ-019 Channel status 8'h80-8'hEF in any state: latch as running status, go to WAIT_D1, discard any partial message.
REQ-020 Status 8'hF0-8'hF7 in any state: clear running status, go to SKIP.
REQ-021 Data byte (bit7=0) in NO_STAT or SKIP: discard, state unchanged.
REQ-022 Data byte in WAIT_D1: store as data1; for status nibble 8'hC/8'hD complete message with data2=0 and stay WAIT_D1; otherwise go WAIT_D2.
REQ-023 Data byte in WAIT_D2: store as data2, complete message, return to WAIT_D1 (running status retained).
REQ-024 Completed message whose status low nibble equals chan_sel, or omni=1, is pushed to the FIFO; non-matching messages are silently discarded (not counted as drops).
REQ-025 Note On (8'h9n) with data2=0 is pushed as status 8'h8n with data2=NOTE_OFF_VEL[6:0]; running status remains 8'h9n.
REQ-026 Push occurs on the clock edge that samples the completing byte; msg_valid rises the following cycle when FIFO was empty (latency 1 clock).
REQ-027 FIFO is first-word-fall-through: msg_status/data1/data2 show the head entry whenever msg_valid=1; pop on msg_valid && msg_ready.
REQ-028 Outputs hold stable while msg_valid=1 and msg_ready=0.
REQ-029 Push when full with no pop in the same cycle: message dropped, overflow set to 1, drop_count incremented, saturating at 255.
REQ-030 Simultaneous push and pop when full: both performed, no drop, fifo_level unchanged.
REQ-031 Simultaneous push and pop when empty: push performed, pop ignored (msg_valid was 0).
REQ-032 Read and write pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
REQ-033 msg_ready while msg_valid=0 has no effect.
REQ-034 omni/chan_sel are sampled at message completion only; changes do not affect messages already queued.

Reset
REQ-035 Asserting reset at any time, including mid-message, forces state NO_STAT, clears running status and partial data, empties FIFO.
REQ-036 During and after reset: msg_valid=0, fifo_level=0, overflow=0, drop_count=0, msg_status/data1/data2=0.
REQ-037 The first byte_valid after reset release is processed normally.

Verification
REQ-038 omni=1, bytes 90 3C 64 -> one cycle after byte 64: msg_valid=1, status 90, data1 3C, data2 64, fifo_level=1.
REQ-039 Running status: 90 3C 64 3E 00 -> two entries: (90,3C,64) then (80,3E,40); an F8 inserted between 3E and 00 yields the same result.
REQ-040 omni=0, chan_sel=2: C2 05, C3 07, 82 40 10 -> FIFO holds (C2,05,00) and (82,40,10) only.
REQ-041 FIFO_DEPTH=8, msg_ready=0, 10 complete messages -> fifo_level=8, overflow=1, drop_count=2; drain 8 in original order.
REQ-042 Full FIFO, push coinciding with msg_ready=1 -> no drop, fifo_level stays 8, drop_count unchanged.
REQ-043 F0 7E 01 F7 then 3C 40, then reset asserted after 90 3C -> nothing queued; after reset, 40 alone is discarded, outputs all zero.
